// File: rtl/serial_operand_serializer_msb_first.sv
// serial_operand_serializer_msb_first
// Accepts an operand pair (A, B) over a valid/ready handshake and streams it
// MSB first, one bit per cycle. A one-cycle clear pulse precedes every word so
// a downstream serial comparator restarts in its "equal" state.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   in_valid/in_ready  parallel operand handshake (ready only while idle)
//   in_a, in_b         parallel operands, WIDTH bits
//   out_clear          one-cycle pulse ahead of each word (comparator reset)
//   out_valid          out_a/out_b carry a valid bit
//   out_a, out_b       serial operand bits, MSB first
//   out_first          current bit is bit WIDTH-1
//   out_last           current bit is bit 0
//
// Optional feature, macro SERIALIZER_RESULT_CAPTURE_EN:
//   cmp_lt/cmp_eq/cmp_gt  comparator combinational result inputs
//   res_valid             one-cycle pulse when res_* are updated
//   res_lt/res_eq/res_gt  comparator result captured at the end of each word
module serial_operand_serializer_msb_first #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_clear,
  output logic             out_valid,
  output logic             out_a,
  output logic             out_b,
  output logic             out_first,
  output logic             out_last
`ifdef SERIALIZER_RESULT_CAPTURE_EN
  ,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  output logic             res_valid,
  output logic             res_lt,
  output logic             res_eq,
  output logic             res_gt
`endif
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_SHIFT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic             in_ready_q, in_ready_d;
  logic             out_clear_q, out_clear_d;
  logic             out_valid_q, out_valid_d;
  logic             out_first_q, out_first_d;
  logic             out_last_q, out_last_d;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_a_d      = sh_a_q;
    sh_b_d      = sh_b_q;
    in_ready_d  = 1'b0;
    out_clear_d = 1'b0;
    out_valid_d = 1'b0;
    out_first_d = 1'b0;
    out_last_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sh_a_d  = in_a;
          sh_b_d  = in_b;
          cnt_d   = CW'(WIDTH - 1);
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        sh_a_d = {sh_a_q[WIDTH-2:0], 1'b0};
        sh_b_d = {sh_b_q[WIDTH-2:0], 1'b0};
        // Counter holds at zero on the final bit; it is only reloaded in idle
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with state_q
    in_ready_d  = (state_d == S_IDLE);
    out_clear_d = (state_d == S_CLEAR);
    out_valid_d = (state_d == S_SHIFT);
    out_first_d = (state_d == S_SHIFT) && (cnt_d == CW'(WIDTH - 1));
    out_last_d  = (state_d == S_SHIFT) && (cnt_d == '0);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      in_ready_q  <= 1'b1;
      out_clear_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_a_q      <= sh_a_d;
      sh_b_q      <= sh_b_d;
      in_ready_q  <= in_ready_d;
      out_clear_q <= out_clear_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_clear = out_clear_q;
  assign out_valid = out_valid_q;
  assign out_a     = sh_a_q[WIDTH-1];
  assign out_b     = sh_b_q[WIDTH-1];
  assign out_first = out_first_q;
  assign out_last  = out_last_q;

`ifdef SERIALIZER_RESULT_CAPTURE_EN
  logic word_end;
  logic res_valid_q, res_lt_q, res_eq_q, res_gt_q;

  // The comparator has consumed bit 0 by the edge that ends the last-bit cycle
  assign word_end = (state_q == S_SHIFT) && (cnt_q == '0);

  // Result capture: res_* hold until the next word completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_lt_q    <= 1'b0;
      res_eq_q    <= 1'b0;
      res_gt_q    <= 1'b0;
    end else begin
      res_valid_q <= word_end;
      if (word_end) begin
        res_lt_q <= cmp_lt;
        res_eq_q <= cmp_eq;
        res_gt_q <= cmp_gt;
      end
    end
  end

  assign res_valid = res_valid_q;
  assign res_lt    = res_lt_q;
  assign res_eq    = res_eq_q;
  assign res_gt    = res_gt_q;
`endif

endmodule
